// File: rtl/ghostchip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ghostchip_pkg
//  Brief    : Shared display geometry, pixel type and draw-engine state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package ghostchip_pkg;

    localparam int SCREEN_W = 128;
    localparam int SCREEN_H = 64;
    localparam int LORES_W  = 64;
    localparam int LORES_H  = 32;

    typedef logic [1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_FETCH2 = 3'd3,
        ST_LATCH2 = 3'd4,
        ST_SCAN   = 3'd5,
        ST_WR     = 3'd6,
        ST_DONE   = 3'd7
    } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_row_fetch
//  Brief    : Reads one sprite row (one or two bytes) from main memory and
//             presents it as a left-justified 16-bit word with a valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_row_fetch
    import ghostchip_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              wide_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       row_o,
    output logic              row_valid_o
);

    draw_state_t       ph_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q       <= ST_IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            hi_q       <= '0;
        end else begin
            case (ph_q)
                ST_IDLE: begin
                    if (req_i) begin
                        ph_q       <= ST_FETCH;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= base_i;
                    end
                end
                ST_FETCH: begin
                    ph_q     <= ST_LATCH;
                    mem_rd_q <= 1'b0;
                end
                ST_LATCH: begin
                    hi_q <= mem_rdata_i;
                    if (wide_i) begin
                        ph_q       <= ST_FETCH2;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    end else begin
                        ph_q <= ST_IDLE;
                    end
                end
                ST_FETCH2: begin
                    ph_q     <= ST_LATCH2;
                    mem_rd_q <= 1'b0;
                end
                default: ph_q <= ST_IDLE;
            endcase
        end
    end

    // Read data arrives in the latch cycle, so the word is forwarded straight through.
    assign row_o       = wide_i ? {hi_q, mem_rdata_i} : {mem_rdata_i, 8'h00};
    assign row_valid_o = ((ph_q == ST_LATCH) && !wide_i) || (ph_q == ST_LATCH2);
    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = mem_addr_q;

endmodule
`default_nettype wire

// File: rtl/sprite_draw.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_draw
//  Brief    : DXYN sprite engine: fetches sprite rows, clips, and XOR-draws into
//             the 2-bit frame store with read-modify-write, reporting collision.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_draw
    import ghostchip_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hires,
    input  logic [1:0]        plane_mask,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [6:0]        hpos,
    output logic [5:0]        vpos,
    output logic [1:0]        pixeli,
    input  logic [1:0]        pixelo,
    output logic              we
);

    draw_state_t       state_q;
    logic [6:0]        ox_q;
    logic [5:0]        oy_q;
    logic              hires_q;
    logic              wide_q;
    pixel_t            mask_q;
    logic [3:0]        last_row_q;
    logic [3:0]        row_q;
    logic [3:0]        col_q;
    logic [1:0]        sub_q;
    logic [15:0]       bits_q;
    logic [ADDR_W-1:0] row_addr_q;
    logic              coll_q;

    logic              w_accept;
    logic [7:0]        w_px;
    logic [6:0]        w_py;
    logic              w_visible;
    logic              w_bit;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_advance;
    logic              w_next_row;
    logic              w_fetch_req;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_fetch_base;
    logic [15:0]       w_row_word;
    logic              w_row_valid;
    logic              w_unused;

    assign w_unused = ^{x[7], y[7:6]};

    assign w_accept   = (state_q == ST_IDLE) && start;
    assign w_px       = {1'b0, ox_q} + {4'b0, col_q};
    assign w_py       = {1'b0, oy_q} + {3'b0, row_q};
    // Clip against the logical screen; lores coordinates are pre-scaling.
    assign w_visible  = hires_q ? ((w_px < 8'(SCREEN_W)) && (w_py < 7'(SCREEN_H)))
                                : ((w_px < 8'(LORES_W))  && (w_py < 7'(LORES_H)));
    assign w_bit      = bits_q[~col_q];
    assign w_col_last = (col_q == (wide_q ? 4'd15 : 4'd7));
    assign w_row_last = (row_q == last_row_q);

    assign w_advance  = ((state_q == ST_SCAN) && !(w_bit && w_visible)) ||
                        ((state_q == ST_WR) && (hires_q || (sub_q == 2'd3)));
    assign w_next_row   = w_advance && w_col_last && !w_row_last;
    assign w_fetch_req  = w_accept || w_next_row;
    assign w_next_addr  = row_addr_q + (wide_q ? ADDR_W'(2) : ADDR_W'(1));
    assign w_fetch_base = w_accept ? addr : w_next_addr;

    sprite_row_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk         (clk),
        .reset       (reset),
        .req_i       (w_fetch_req),
        .wide_i      (wide_q),
        .base_i      (w_fetch_base),
        .mem_rdata_i (mem_rdata),
        .mem_rd_o    (mem_rd),
        .mem_addr_o  (mem_addr),
        .row_o       (w_row_word),
        .row_valid_o (w_row_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            hires_q    <= 1'b0;
            wide_q     <= 1'b0;
            mask_q     <= '0;
            last_row_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            sub_q      <= '0;
            bits_q     <= '0;
            row_addr_q <= '0;
            coll_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ox_q       <= hires ? x[6:0] : {1'b0, x[5:0]};
                        oy_q       <= hires ? y[5:0] : {1'b0, y[4:0]};
                        hires_q    <= hires;
                        wide_q     <= (n == 4'd0);
                        last_row_q <= (n == 4'd0) ? 4'd15 : n - 4'd1;
                        mask_q     <= plane_mask;
                        row_q      <= '0;
                        col_q      <= '0;
                        sub_q      <= '0;
                        row_addr_q <= addr;
                        coll_q     <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_row_valid) begin
                        bits_q  <= w_row_word;
                        col_q   <= '0;
                        sub_q   <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_advance) begin
                        state_q <= ST_WR;
                    end
                end
                ST_WR: begin
                    if ((pixelo & mask_q) != 2'b00) begin
                        coll_q <= 1'b1;
                    end
                    if (!w_advance) begin
                        sub_q   <= sub_q + 2'd1;
                        state_q <= ST_SCAN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Column/row stepping shared by skipped columns and finished writes.
            if (w_advance) begin
                sub_q <= '0;
                if (!w_col_last) begin
                    col_q   <= col_q + 4'd1;
                    state_q <= ST_SCAN;
                end else if (!w_row_last) begin
                    row_q      <= row_q + 4'd1;
                    row_addr_q <= w_next_addr;
                    state_q    <= ST_FETCH;
                end else begin
                    state_q <= ST_DONE;
                end
            end
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign collision = coll_q;
    assign we        = (state_q == ST_WR);
    assign hpos      = ((state_q == ST_SCAN) || we) ? (hires_q ? w_px[6:0] : {w_px[5:0], sub_q[0]}) : '0;
    assign vpos      = ((state_q == ST_SCAN) || we) ? (hires_q ? w_py[5:0] : {w_py[4:0], sub_q[1]}) : '0;
    assign pixeli    = we ? (pixelo ^ mask_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_draw
//  Brief    : Scoreboard bench for sprite_draw with memory and frame-store models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_draw;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        x, y;
    logic [3:0]        n;
    logic [ADDR_W-1:0] addr;
    logic              hires;
    logic [1:0]        plane_mask;
    logic              busy, done, collision, mem_rd, we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [6:0]        hpos;
    logic [5:0]        vpos;
    logic [1:0]        pixeli, pixelo;

    always #5 clk = ~clk;

    sprite_draw #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x          (x),
        .y          (y),
        .n          (n),
        .addr       (addr),
        .hires      (hires),
        .plane_mask (plane_mask),
        .busy       (busy),
        .done       (done),
        .collision  (collision),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixeli     (pixeli),
        .pixelo     (pixelo),
        .we         (we)
    );

    logic [7:0] mem  [0:4095];
    logic [1:0] vram [0:63][0:127];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        pixelo <= vram[vpos][hpos];
        if (we) vram[vpos][hpos] <= pixeli;
    end

    typedef struct packed {
        logic [6:0] h;
        logic [5:0] v;
        logic [1:0] d;
    } wr_t;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    int                exp_lat[$];
    logic              exp_coll[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rise    = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
    endtask

    // Monitor: compare every DUT event against the queued expectations.
    always @(negedge clk) begin
        wr_t e;
        if (we) begin
            if (exp_wr.size() == 0) unexpected("write");
            else begin
                e = exp_wr.pop_front();
                chk("wr_hpos", hpos, e.h);
                chk("wr_vpos", vpos, e.v);
                chk("wr_data", pixeli, e.d);
            end
        end
        if (mem_rd) begin
            if (exp_rd.size() == 0) unexpected("mem_rd");
            else chk("mem_addr", mem_addr, exp_rd.pop_front());
        end
        if (busy && !busy_prev) rise = cyc;
        if (done) begin
            if (exp_lat.size() == 0) unexpected("done");
            else begin
                chk("done_latency", cyc - rise, exp_lat.pop_front());
                chk("collision", collision, exp_coll.pop_front());
            end
        end
        busy_prev = busy;
    end

    task automatic push_wr(input int h, input int v, input int d);
        exp_wr.push_back('{h: 7'(h), v: 6'(v), d: 2'(d)});
    endtask

    task automatic push_done(input int lat, input logic c);
        exp_lat.push_back(lat);
        exp_coll.push_back(c);
    endtask

    task automatic issue(input int xi, input int yi, input int ni, input int ai,
                         input logic hi, input int mk);
        @(negedge clk);
        x = 8'(xi); y = 8'(yi); n = 4'(ni); addr = ADDR_W'(ai);
        hires = hi; plane_mask = 2'(mk); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", nm, k);
        end
        @(negedge clk);
        chk({nm, "_writes_left"}, exp_wr.size(), 0);
        chk({nm, "_reads_left"}, exp_rd.size(), 0);
        chk({nm, "_done_left"}, exp_lat.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0; n = '0; addr = '0;
        hires = 1'b1; plane_mask = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++) vram[r][c] = 2'b00;
        mem[12'h300] = 8'h80;
        mem[12'h301] = 8'hFF;
        mem[12'h302] = 8'h80;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_collision", collision, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_hpos", hpos, 0);
        chk("rst_vpos", vpos, 0);
        chk("rst_pixeli", pixeli, 0);
        chk("rst_we", we, 0);
        reset = 1'b0;

        // Single pixel draw, then erase, then mask 0 rewrite.
        exp_rd.push_back(12'h300); push_wr(5, 3, 1); push_done(11, 1'b0);
        issue(5, 3, 1, 12'h300, 1'b1, 1);
        wait_done("single");
        exp_rd.push_back(12'h300); push_wr(5, 3, 0); push_done(11, 1'b1);
        issue(5, 3, 1, 12'h300, 1'b1, 1);
        wait_done("erase");
        exp_rd.push_back(12'h300); push_wr(5, 3, 0); push_done(11, 1'b0);
        issue(5, 3, 1, 12'h300, 1'b1, 0);
        wait_done("mask0");

        // Origin wrap, then right-edge clip.
        exp_rd.push_back(12'h301);
        for (int c = 2; c < 10; c++) push_wr(c, 2, 1);
        push_done(18, 1'b0);
        issue(130, 2, 1, 12'h301, 1'b1, 1);
        wait_done("wrap");
        exp_rd.push_back(12'h301);
        for (int c = 124; c < 128; c++) push_wr(c, 63, 1);
        push_done(14, 1'b0);
        issue(124, 63, 1, 12'h301, 1'b1, 1);
        wait_done("clip");

        // Lores 2x2 scaling.
        exp_rd.push_back(12'h302);
        push_wr(20, 8, 3); push_wr(21, 8, 3); push_wr(20, 9, 3); push_wr(21, 9, 3);
        push_done(17, 1'b0);
        issue(10, 4, 1, 12'h302, 1'b0, 3);
        wait_done("lores");

        // 16x16 blank sprite: 32 reads in order, 16 rows x 20 cycles; a start
        // pulse while busy must be ignored.
        for (int a = 12'h200; a < 12'h220; a++) exp_rd.push_back(ADDR_W'(a));
        push_done(320, 1'b0);
        issue(0, 0, 0, 12'h200, 1'b1, 1);
        repeat (5) @(negedge clk);
        x = 8'd0; y = 8'd0; n = 4'd1; addr = 12'h300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("big");

        // Reset during WR aborts the command with no done pulse.
        exp_rd.push_back(12'h300); push_wr(40, 10, 1);
        issue(40, 10, 1, 12'h300, 1'b1, 1);
        begin
            int k = 0;
            while (!we && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("abort_reached_wr", we, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_mem_rd_idle", mem_rd, 0);
        exp_rd.push_back(12'h300); push_wr(40, 10, 0); push_done(11, 1'b1);
        issue(40, 10, 1, 12'h300, 1'b1, 1);
        wait_done("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_draw.md
Name: sprite_draw

Overview:
Sprite draw engine for the CHIP-8/SCHIP/XO-CHIP display path. It executes one DXYN draw command. It fetches sprite bytes from main memory, then read-modify-writes the 128x64, 2-bit frame store through its single-port vram interface, XORing set sprite bits with a plane mask. It reports collision (VF) to the CPU and sits directly upstream of vram on its hpos/vpos/pixeli/pixelo/we port.

Parameters:
ADDR_W, 12, main-memory address width (16 for XO-CHIP builds)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; accepted only when busy=0
x  in  8  VX sprite origin column
y  in  8  VY sprite origin row
n  in  4  rows; 0 = 16x16 sprite
addr  in  ADDR_W  I register, first sprite byte
hires  in  1  1 = 128x64 mode, 0 = 64x32 mode (2x2 scaled)
plane_mask  in  2  pixel bits toggled per set sprite bit
busy  out  1  command in progress
done  out  1  one-cycle pulse when the command completes
collision  out  1  VF result; valid from done until next accepted start
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  8  read data, valid the cycle after mem_rd
hpos  out  7  vram column
vpos  out  6  vram row
pixeli  out  2  vram write data
pixelo  in  2  vram read data, registered: valid the cycle after address driven
we  out  1  vram write enable

Behaviour:
- Reset values: busy=0, done=0, collision=0, mem_rd=0, mem_addr=0, hpos=0, vpos=0, pixeli=0, we=0. State goes to IDLE.
- Reset mid-command aborts the command immediately. No further we or mem_rd is issued, and no done pulse is generated.
- Inputs are latched when a start is accepted:
  - Origin is wrapped: hires ox=x mod 128, oy=y mod 64; lores ox=x mod 64, oy=y mod 32.
  - width=16 and rows=16 if n=0, else width=8 and rows=n.
  - collision is cleared at accept.
- start while busy=1 is ignored.
- States: IDLE, FETCH, LATCH, FETCH2, LATCH2, SCAN, WR, DONE.
- IDLE: on start, go to FETCH, and busy=1 from the next cycle.
- FETCH: mem_rd=1 with mem_addr = addr + row*(width/8). Next state LATCH.
- LATCH: capture mem_rdata as the row high byte. If width=16, go to FETCH2 (mem_addr+1), then LATCH2 (low byte). Otherwise go to SCAN with col=0.
- Sprite bits are taken MSB first.
- SCAN, one column per visit:
  - Target position: hires px=ox+col, py=oy+row. Lores uses the 2x2 block at (2*(ox+col)+sx, 2*(oy+row)+sy), sub-pixels in order (0,0),(1,0),(0,1),(1,1).
  - Clipping: a target is visible when px<128 and py<64 (lores: ox+col<64 and oy+row<32). Off-edge pixels are clipped, never wrapped.
  - If the bit is clear or the target is clipped: advance col in 1 cycle.
  - Otherwise drive hpos/vpos with we=0 (read cycle), then go to WR.
- WR: hold hpos/vpos, we=1, pixeli = pixelo ^ plane_mask. If (pixelo & plane_mask) != 0, set collision.
  - Lores: return to SCAN for the next sub-pixel. The column advances after the 4th sub-pixel.
  - Cost per set visible pixel: 2 cycles hires, 8 cycles lores.
- After the last column: if more rows remain, go to FETCH for the next row; if this was the last row, go to DONE.
- Sprite byte addresses wrap modulo 2^ADDR_W.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- collision holds its value until the next accepted start.
- we is asserted only in WR. mem_rd is asserted only in FETCH/FETCH2.
- plane_mask=0: the full sequence runs and writes back unchanged data, with collision=0.

Decomposition:
- Shared package ghostchip_pkg holds:
  - SCREEN_W=128, SCREEN_H=64, LORES_W=64, LORES_H=32.
  - The draw-state enum.
  - The pixel_t 2-bit typedef.
- One natural sub-module: sprite_row_fetch. It runs FETCH/LATCH/FETCH2/LATCH2 and delivers a 16-bit row word plus a valid strobe. Clipping and read-modify-write stay in sprite_draw.

Test Plan:
- Hires single pixel: vram all 0; x=5, y=3, n=1, byte 0x80, mask=01. Expect exactly one we, at (5,3) with pixeli=01; done 11 cycles after accept; collision=0.
- Erase with collision: repeat the single-pixel command. Expect pixeli=00 at (5,3) and collision=1.
- Clip and wrap: x=130, y=2, hires, byte 0xFF. Expect the origin wrapped to col 2. Then x=124, y=63, byte 0xFF: exactly 4 writes at cols 124..127, and no writes at cols 0..3.
- Lores scaling: x=10, y=4, hires=0, byte 0x80, mask=11. Expect 4 writes at (20,8),(21,8),(20,9),(21,9) with data 11.
- 16x16: n=0, addr=0x200. Expect 32 mem_rd at 0x200..0x21F in order, and 256 columns scanned.
- Reset mid-command: assert reset during a WR cycle. Next cycle: we=0, busy=0, no done pulse; a fresh start is accepted afterwards.
